can_rx_fifo: RTL

Receive-frame buffer and acceptance filter placed directly downstream of the CAN controller's receiver. It captures each completed, CRC-valid frame (ID, EXT, RTR, DLC, 8 data bytes) on a one-cycle strobe. Frames that pass a programmable ID mask/match filter are queued in a DEPTH-entry FIFO. The TinyQV core reads the head frame through a 32-bit register window and pops it explicitly. The FIFO raises an interrupt when it is non-empty or has overflowed.

---
 rtl/can_rx_fifo.sv | 99 +++++++++
 1 files changed

// File: rtl/can_rx_fifo.sv
// can_rx_fifo: acceptance-filtered receive frame FIFO with a 32-bit register window
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   frm_valid/id/ext/rtr/dlc/data  completed CRC-good frame from the CAN receiver
//   cs, we, rs, d              register access (rs selects one of 8 32-bit registers)
//   q                          combinational read data, 0 unless cs & ~we
//   irq                        level interrupt: non-empty and/or overflow, gated by irqen
module can_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frm_valid,
  input  logic [28:0] frm_id,
  input  logic        frm_ext,
  input  logic        frm_rtr,
  input  logic [3:0]  frm_dlc,
  input  logic [63:0] frm_data,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  rs,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        irq
);
  localparam int CW = AW + 1;
  // frame word layout: {ext, rtr, dlc[3:0], id[28:0], data[63:0]}
  logic [98:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    irqen_q, irqen_d;
  logic [28:0]   match_id_q, match_id_d, mask_id_q, mask_id_d;
  logic          match_ext_q, match_ext_d, mask_ext_q, mask_ext_d;
  logic          acc, wr_ctl, pop, push, ovf_evt, empty, full;
  logic [98:0]   head;
  logic          unused;
  assign unused = d[29];
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign acc = (((frm_id ^ match_id_q) & mask_id_q) == '0) && (!mask_ext_q || frm_ext == match_ext_q);
  assign wr_ctl = cs & we & (rs == 3'd3);
  assign pop = wr_ctl & d[8] & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the frame
  assign push = frm_valid & acc & (~full | pop);
  assign ovf_evt = frm_valid & acc & full & ~pop;
  assign head = empty ? '0 : mem_q[rd_ptr_q];
  assign irq = (irqen_q[0] & ~empty) | (irqen_q[1] & ovf_q);
  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    // an overflow in the same cycle as a clear keeps the flag set
    ovf_d = ovf_evt ? 1'b1 : (wr_ctl & d[9]) ? 1'b0 : ovf_q;
    irqen_d = wr_ctl ? d[31:30] : irqen_q;
    match_id_d = (cs & we & rs == 3'd4) ? d[28:0] : match_id_q;
    match_ext_d = (cs & we & rs == 3'd4) ? d[31] : match_ext_q;
    mask_id_d = (cs & we & rs == 3'd5) ? d[28:0] : mask_id_q;
    mask_ext_d = (cs & we & rs == 3'd5) ? d[31] : mask_ext_q;
  end
  always_comb begin
    q = '0;
    if (cs & ~we)
      case (rs)
        3'd0: q = {head[98:97], 1'b0, head[92:64]};
        3'd1: q = head[31:0];
        3'd2: q = head[63:32];
        3'd3: q = {irqen_q, 9'b0, 5'(count_q), 6'b0, ovf_q, full, empty, 3'b0, head[96:93]};
        3'd4: q = {match_ext_q, 2'b0, match_id_q};
        3'd5: q = {mask_ext_q, 2'b0, mask_id_q};
        default: q = '0;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      irqen_q <= '0;
      match_id_q <= '0;
      match_ext_q <= 1'b0;
      mask_id_q <= '0;
      mask_ext_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      irqen_q <= irqen_d;
      match_id_q <= match_id_d;
      match_ext_q <= match_ext_d;
      mask_id_q <= mask_id_d;
      mask_ext_q <= mask_ext_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {frm_ext, frm_rtr, frm_dlc, frm_id, frm_data};
endmodule
